// File: rtl/ahb_arbiter_slave_pkg.sv
// AHB_package: shared AHB types and constants for the generated interconnect.
// The burst-break option of the slave arbiter is compiled in with the macro
// AHB_ARB_BURST_LIMIT_EN; the beat limit constant below is its default.
package AHB_package;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_type;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_OWN     = 2'b01,
        ARB_RELEASE = 2'b10
    } arb_state_type;

    localparam int AHB_ARB_MAX_BEATS = 16;

    // A beat only counts toward a tenure when it actually moves data.
    function automatic logic is_active_beat(input htrans_type t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_arbiter_slave_rr_picker.sv
// ahb_rr_picker: combinational round-robin picker shared by the generated
// arbiters. Searches upward from the start pointer (wrapping) and returns the
// first eligible request as a one-hot winner plus a valid flag.
module ahb_rr_picker #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    input  logic [N-1:0]  exclude,
    output logic [N-1:0]  winner,
    output logic          valid
);

    logic [N-1:0]  eligible;
    logic [IW-1:0] idx;

    assign eligible = req & ~exclude;

    // Walk the request vector starting at the pointer; the first hit wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(start) + i) % N);
            if (!valid && eligible[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter_slave.sv
// ahb_arbiter_slave: per-slave-port round-robin arbiter. Ownership moves only
// on hready boundaries. Defining AHB_ARB_BURST_LIMIT_EN adds a beat counter
// that forces a long tenure to break when another master is waiting.
module ahb_arbiter_slave #(
    parameter int SLAVE_X_MASTER_NUM = 4,
    parameter int AHB_ARB_MAX_BEATS  = AHB_package::AHB_ARB_MAX_BEATS,
    localparam int MW = $clog2(SLAVE_X_MASTER_NUM)
) (
    input  logic                          hclk,
    input  logic                          hreset,
    input  logic [SLAVE_X_MASTER_NUM-1:0] hreq,
    input  AHB_package::htrans_type       htrans,
    input  logic                          hready,
    output logic [SLAVE_X_MASTER_NUM-1:0] hgrant,
    output logic [MW-1:0]                 hmaster,
    output logic                          hsel,
    output logic [SLAVE_X_MASTER_NUM-1:0] hlast
);

    import AHB_package::*;

    localparam int M = SLAVE_X_MASTER_NUM;
    localparam logic [MW-1:0] LAST_IDX = MW'(M - 1);

    arb_state_type state, next_state;
    logic [M-1:0]  grant_q, grant_d;
    logic [MW-1:0] master_q, master_d;
    logic [MW-1:0] last_q, last_d;
    logic          sel_q;
    logic [MW-1:0] start_ptr;
    logic [MW-1:0] pick_idx;
    logic [M-1:0]  pick_grant;
    logic [M-1:0]  pick_exclude;
    logic          pick_valid;
    logic          owner_req;
    logic          rearb;

    assign start_ptr = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;
    assign owner_req = |(hreq & grant_q);

`ifdef AHB_ARB_BURST_LIMIT_EN
    localparam int CW = $clog2(AHB_ARB_MAX_BEATS + 1);
    localparam logic [CW-1:0] BEAT_MAX = CW'(AHB_ARB_MAX_BEATS);

    logic [CW-1:0] beat_q, beat_d, beat_inc;
    logic [M-1:0]  hlast_q, hlast_d;
    logic          others_pending;

    assign others_pending = |(hreq & ~grant_q);
    assign beat_inc = (is_active_beat(htrans) && (beat_q != BEAT_MAX)) ? beat_q + 1'b1 : beat_q;
    assign pick_exclude = (state == ARB_RELEASE) ? grant_q : '0;
    assign hlast = hlast_q;
`else
    localparam int unused_max_beats = AHB_ARB_MAX_BEATS;
    logic unused_htrans;

    assign unused_htrans = ^htrans;
    assign pick_exclude = '0;
    assign hlast = '0;
`endif

    ahb_rr_picker #(
        .N(M)
    ) u_picker (
        .req     (hreq),
        .start   (start_ptr),
        .exclude (pick_exclude),
        .winner  (pick_grant),
        .valid   (pick_valid)
    );

    // Convert the one-hot winner into the owner index for the mux steering.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < M; i++) begin
            if (pick_grant[i]) begin
                pick_idx = MW'(i);
            end
        end
    end

    // Next-state logic: decide when to rearbitrate, then apply the picker result.
    always_comb begin
        next_state = state;
        grant_d    = grant_q;
        master_d   = master_q;
        last_d     = last_q;
        rearb      = 1'b0;
`ifdef AHB_ARB_BURST_LIMIT_EN
        beat_d     = beat_q;
        hlast_d    = '0;
`endif
        case (state)
            ARB_IDLE: begin
                rearb = hready;
            end
            ARB_OWN: begin
                if (hready) begin
                    if (!owner_req) begin
                        rearb = 1'b1;
`ifdef AHB_ARB_BURST_LIMIT_EN
                    end else if ((beat_inc == BEAT_MAX) && others_pending) begin
                        beat_d     = beat_inc;
                        hlast_d    = grant_q;
                        next_state = ARB_RELEASE;
                    end else begin
                        beat_d = beat_inc;
`endif
                    end
                end
            end
`ifdef AHB_ARB_BURST_LIMIT_EN
            ARB_RELEASE: begin
                rearb = hready;
            end
`endif
            default: begin
                next_state = ARB_IDLE;
                grant_d    = '0;
            end
        endcase

        if (rearb) begin
            if (pick_valid) begin
                grant_d    = pick_grant;
                master_d   = pick_idx;
                last_d     = pick_idx;
                next_state = ARB_OWN;
            end else begin
                grant_d    = '0;
                next_state = ARB_IDLE;
            end
`ifdef AHB_ARB_BURST_LIMIT_EN
            beat_d = '0;
`endif
        end
    end

    // State and ownership registers; last owner starts at M-1 so master 0 leads.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state    <= ARB_IDLE;
            grant_q  <= '0;
            master_q <= '0;
            last_q   <= LAST_IDX;
            sel_q    <= 1'b0;
        end else begin
            state    <= next_state;
            grant_q  <= grant_d;
            master_q <= master_d;
            last_q   <= last_d;
            sel_q    <= |grant_d;
        end
    end

`ifdef AHB_ARB_BURST_LIMIT_EN
    // Beat counter and burst-break pulse; reset drops any pulse in flight.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            beat_q  <= '0;
            hlast_q <= '0;
        end else begin
            beat_q  <= beat_d;
            hlast_q <= hlast_d;
        end
    end
`endif

    assign hgrant  = grant_q;
    assign hmaster = master_q;
    assign hsel    = sel_q;

endmodule

// File: tb/tb_ahb_arbiter_slave.sv
// tb_ahb_arbiter_slave: directed scoreboard bench for ahb_arbiter_slave with
// four masters and a beat limit of 4 (effective when AHB_ARB_BURST_LIMIT_EN is set).
module tb_ahb_arbiter_slave;

    import AHB_package::*;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] master;
        logic       chk_master;
        logic       sel;
        logic [3:0] last;
        string      tag;
    } exp_t;

    logic       hclk;
    logic       hreset;
    logic [3:0] hreq;
    htrans_type htrans;
    logic       hready;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hsel;
    logic [3:0] hlast;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    ahb_arbiter_slave #(
        .SLAVE_X_MASTER_NUM (4),
        .AHB_ARB_MAX_BEATS  (4)
    ) dut (
        .hclk    (hclk),
        .hreset  (hreset),
        .hreq    (hreq),
        .htrans  (htrans),
        .hready  (hready),
        .hgrant  (hgrant),
        .hmaster (hmaster),
        .hsel    (hsel),
        .hlast   (hlast)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Pop the oldest expectation and compare it with the registered outputs.
    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            failed++;
            $error("[TB] FAIL scoreboard_empty got 0 entries want 1");
        end else begin
            e = sb.pop_front();
            total++;
            assert (hgrant === e.grant) passed++;
            else begin
                failed++;
                $error("[TB] FAIL %s hgrant got %b want %b", e.tag, hgrant, e.grant);
            end
            total++;
            assert (hsel === e.sel) passed++;
            else begin
                failed++;
                $error("[TB] FAIL %s hsel got %b want %b", e.tag, hsel, e.sel);
            end
            total++;
            assert (hlast === e.last) passed++;
            else begin
                failed++;
                $error("[TB] FAIL %s hlast got %b want %b", e.tag, hlast, e.last);
            end
            if (e.chk_master) begin
                total++;
                assert (hmaster === e.master) passed++;
                else begin
                    failed++;
                    $error("[TB] FAIL %s hmaster got %0d want %0d", e.tag, hmaster, e.master);
                end
            end
        end
    endtask

    // Drive one cycle of inputs at the falling edge, record the expected result
    // for the following rising edge, and check it just after that edge.
    task automatic applyStimulus(input logic [3:0] req, input htrans_type tr,
                                 input logic rdy, input logic rst,
                                 input logic [3:0] eg, input logic [1:0] em,
                                 input logic chkm, input logic [3:0] el,
                                 input string tag);
        exp_t e;
        @(negedge hclk);
        hreq   = req;
        htrans = tr;
        hready = rdy;
        hreset = rst;
        e.grant      = eg;
        e.master     = em;
        e.chk_master = chkm;
        e.sel        = |eg;
        e.last       = el;
        e.tag        = tag;
        sb.push_back(e);
        @(posedge hclk);
        #1;
        checkOutput();
    endtask

    initial begin
        hreset = 1'b1;
        hreq   = 4'b0000;
        htrans = HTRANS_IDLE;
        hready = 1'b1;

        // Reset state.
        applyStimulus(4'b0000, HTRANS_IDLE,   1, 1, 4'b0000, 2'd0, 1, 4'b0000, "reset");

        // Basic grant and handover to master 2.
        applyStimulus(4'b0101, HTRANS_NONSEQ, 1, 0, 4'b0001, 2'd0, 1, 4'b0000, "t1_grant0");
        applyStimulus(4'b0101, HTRANS_NONSEQ, 1, 0, 4'b0001, 2'd0, 1, 4'b0000, "t1_hold0");
        applyStimulus(4'b0100, HTRANS_NONSEQ, 1, 0, 4'b0100, 2'd2, 1, 4'b0000, "t1_hand2");
        applyStimulus(4'b0000, HTRANS_IDLE,   1, 0, 4'b0000, 2'd0, 0, 4'b0000, "t1_idle");

        // Round-robin order 0,1,2,3,0 with everyone requesting.
        applyStimulus(4'b0000, HTRANS_IDLE,   1, 1, 4'b0000, 2'd0, 1, 4'b0000, "t2_reset");
        applyStimulus(4'b1111, HTRANS_NONSEQ, 1, 0, 4'b0001, 2'd0, 1, 4'b0000, "t2_rr0");
        applyStimulus(4'b1110, HTRANS_NONSEQ, 1, 0, 4'b0010, 2'd1, 1, 4'b0000, "t2_rr1");
        applyStimulus(4'b1101, HTRANS_NONSEQ, 1, 0, 4'b0100, 2'd2, 1, 4'b0000, "t2_rr2");
        applyStimulus(4'b1011, HTRANS_NONSEQ, 1, 0, 4'b1000, 2'd3, 1, 4'b0000, "t2_rr3");
        applyStimulus(4'b0111, HTRANS_NONSEQ, 1, 0, 4'b0001, 2'd0, 1, 4'b0000, "t2_rr0b");
        applyStimulus(4'b0000, HTRANS_IDLE,   1, 0, 4'b0000, 2'd0, 0, 4'b0000, "t2_idle");

        // Grant frozen while hready is low; handover once it returns.
        applyStimulus(4'b0010, HTRANS_NONSEQ, 1, 0, 4'b0010, 2'd1, 1, 4'b0000, "t3_grant1");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1000, HTRANS_NONSEQ, 0, 0, 4'b0010, 2'd1, 1, 4'b0000, "t3_frozen");
        end
        applyStimulus(4'b1000, HTRANS_NONSEQ, 1, 0, 4'b1000, 2'd3, 1, 4'b0000, "t3_hand3");
        applyStimulus(4'b0000, HTRANS_IDLE,   1, 0, 4'b0000, 2'd0, 0, 4'b0000, "t3_idle");

        // Reset in the middle of master 2's tenure, then 1100 picks master 2.
        applyStimulus(4'b0100, HTRANS_NONSEQ, 1, 0, 4'b0100, 2'd2, 1, 4'b0000, "t4_grant2");
        applyStimulus(4'b0100, HTRANS_NONSEQ, 1, 1, 4'b0000, 2'd0, 1, 4'b0000, "t4_midreset");
        applyStimulus(4'b1100, HTRANS_NONSEQ, 1, 0, 4'b0100, 2'd2, 1, 4'b0000, "t4_after");
        applyStimulus(4'b0000, HTRANS_IDLE,   1, 0, 4'b0000, 2'd0, 0, 4'b0000, "t4_idle");

        // Lone master 0 with htrans IDLE, drop to idle, then one-cycle regrant.
        applyStimulus(4'b0001, HTRANS_IDLE,   1, 0, 4'b0001, 2'd0, 1, 4'b0000, "t5_grant0");
        applyStimulus(4'b0000, HTRANS_IDLE,   1, 0, 4'b0000, 2'd0, 0, 4'b0000, "t5_drop");
        applyStimulus(4'b0010, HTRANS_NONSEQ, 1, 0, 4'b0010, 2'd1, 1, 4'b0000, "t5_grant1");
        applyStimulus(4'b0000, HTRANS_IDLE,   1, 0, 4'b0000, 2'd0, 0, 4'b0000, "t5_idle");

        // No grant from idle while hready is low.
        applyStimulus(4'b0001, HTRANS_NONSEQ, 0, 0, 4'b0000, 2'd0, 0, 4'b0000, "t6_idlefrz");
        applyStimulus(4'b0001, HTRANS_NONSEQ, 1, 0, 4'b0001, 2'd0, 1, 4'b0000, "t6_grant0");
        applyStimulus(4'b0000, HTRANS_IDLE,   1, 0, 4'b0000, 2'd0, 0, 4'b0000, "t6_idle");

        // Master 1 bursts while master 3 waits.
        applyStimulus(4'b0010, HTRANS_NONSEQ, 1, 0, 4'b0010, 2'd1, 1, 4'b0000, "t7_grant1");
        applyStimulus(4'b1010, HTRANS_NONSEQ, 1, 0, 4'b0010, 2'd1, 1, 4'b0000, "t7_beat1");
        applyStimulus(4'b1010, HTRANS_SEQ,    1, 0, 4'b0010, 2'd1, 1, 4'b0000, "t7_beat2");
        applyStimulus(4'b1010, HTRANS_SEQ,    1, 0, 4'b0010, 2'd1, 1, 4'b0000, "t7_beat3");
`ifdef AHB_ARB_BURST_LIMIT_EN
        applyStimulus(4'b1010, HTRANS_SEQ,    1, 0, 4'b0010, 2'd1, 1, 4'b0010, "t7_beat4");
        applyStimulus(4'b1010, HTRANS_SEQ,    0, 0, 4'b0010, 2'd1, 1, 4'b0000, "t7_relwait");
        applyStimulus(4'b1010, HTRANS_SEQ,    1, 0, 4'b1000, 2'd3, 1, 4'b0000, "t7_rel3");
`else
        applyStimulus(4'b1010, HTRANS_SEQ,    1, 0, 4'b0010, 2'd1, 1, 4'b0000, "t7_beat4");
        applyStimulus(4'b1010, HTRANS_SEQ,    0, 0, 4'b0010, 2'd1, 1, 4'b0000, "t7_wait");
        applyStimulus(4'b1010, HTRANS_SEQ,    1, 0, 4'b0010, 2'd1, 1, 4'b0000, "t7_keep1");
`endif
        applyStimulus(4'b1000, HTRANS_NONSEQ, 1, 0, 4'b1000, 2'd3, 1, 4'b0000, "t7_own3");
        applyStimulus(4'b0000, HTRANS_IDLE,   1, 0, 4'b0000, 2'd0, 0, 4'b0000, "t7_idle");

        // Long burst without competitor: no pulse, grant kept.
        applyStimulus(4'b0010, HTRANS_NONSEQ, 1, 0, 4'b0010, 2'd1, 1, 4'b0000, "t8_grant1");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'b0010, HTRANS_SEQ, 1, 0, 4'b0010, 2'd1, 1, 4'b0000, "t8_solo");
        end
        applyStimulus(4'b0000, HTRANS_IDLE,   1, 0, 4'b0000, 2'd0, 0, 4'b0000, "t8_idle");

        if (sb.size() != 0) begin
            total++;
            failed++;
            $error("[TB] FAIL scoreboard_left got %0d entries want 0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
